// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl shared definitions: state encoding,
// count width and KEY index constants.
package counter_ctrl_pkg;

    localparam int COUNT_W   = 10;

    localparam int KEY_START = 1;
    localparam int KEY_CLEAR = 2;
    localparam int KEY_LOAD  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_ctrl_key_press.sv
// key_press: synchronizes one active-low key and emits a registered press pulse.
// Optional debounce filter enabled by COUNTER_CTRL_DEBOUNCE_EN.
module key_press #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic CLOCK_50,
    input  logic Reset,
    input  logic key_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    // two-flop synchronizer, released (high) after reset
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

`ifdef COUNTER_CTRL_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DW-1:0] run_len;
    logic          deb;

    // level follows sync2 only after DEBOUNCE_CYCLES differing samples in a row
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            deb     <= 1'b1;
            run_len <= '0;
        end else if (sync2 == deb) begin
            run_len <= '0;
        end else if (run_len == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb     <= sync2;
            run_len <= '0;
        end else begin
            run_len <= run_len + 1'b1;
        end
    end

    assign level = deb;
`else
    assign level = sync2;
`endif

    // falling edge of the filtered level becomes a one-cycle pulse
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            level_q <= 1'b1;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level_q & ~level;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: key-driven start/pause/clear/load sequencer for a prescaled
// 10-bit counter. Define COUNTER_CTRL_DEBOUNCE_EN to debounce the keys.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE        = 5_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic               CLOCK_50,
    input  logic               Reset,
    input  logic [3:1]         KEY,
    input  logic [COUNT_W-1:0] SW,
    output logic [COUNT_W-1:0] LEDR,
    output logic               done
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic start_p;
    logic clear_p;
    logic load_p;

    state_t             state;
    state_t             state_n;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_n;
    logic [COUNT_W-1:0] count_inc;
    logic [COUNT_W-1:0] limit;
    logic [COUNT_W-1:0] limit_n;
    logic [PW-1:0]      presc;
    logic [PW-1:0]      presc_n;
    logic               tick;

    key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .key_n    (KEY[KEY_START]),
        .press    (start_p)
    );

    key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .key_n    (KEY[KEY_CLEAR]),
        .press    (clear_p)
    );

    key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .key_n    (KEY[KEY_LOAD]),
        .press    (load_p)
    );

    assign tick      = (state == RUN) && (presc == PRESC_LAST);
    assign count_inc = count + 1'b1;

    // state, count, limit and prescaler registers
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
            limit <= '0;
            presc <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            limit <= limit_n;
            presc <= presc_n;
        end
    end

    // next state: clear beats start beats load; commands swallow a same-cycle tick
    always_comb begin
        state_n = state;
        count_n = count;
        limit_n = limit;
        presc_n = presc;

        if (state == RUN) begin
            presc_n = tick ? '0 : presc + 1'b1;
        end else if (state != PAUSE) begin
            presc_n = '0;
        end

        if (clear_p) begin
            state_n = IDLE;
            count_n = '0;
            presc_n = '0;
        end else if (start_p) begin
            unique case (state)
                IDLE:  state_n = RUN;
                RUN:   state_n = PAUSE;
                PAUSE: state_n = RUN;
                DONE: begin
                    state_n = RUN;
                    count_n = '0;
                    presc_n = '0;
                end
            endcase
        end else begin
            if (load_p && (state == IDLE || state == PAUSE)) begin
                limit_n = SW;
            end
            if (tick) begin
                if (limit != '0 && count_inc == limit) begin
                    count_n = limit;
                    state_n = DONE;
                end else begin
                    count_n = count_inc;
                end
            end
        end
    end

    assign LEDR = count;
    assign done = (state == DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl with PRESCALE=4.
// Directed scenarios plus random key traffic against a cycle model.
`timescale 1ns/1ps
module tb_counter_ctrl;

    localparam int P   = 4;
    localparam int DEB = 16;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:1] key = 3'b111;
    logic [9:0] sw  = 10'd0;
    logic [9:0] ledr;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_ctrl #(
        .PRESCALE        (P),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .KEY      (key),
        .SW       (sw),
        .LEDR     (ledr),
        .done     (done)
    );

    // reference model: a press is a key seen high then low in the samples
    // taken 4 and 3 edges ago; it acts on the current edge
    int         m_cnt  = 0;
    int         m_lim  = 0;
    int         m_ph   = 0;
    int         m_mode = M_IDLE;
    logic [3:1] h1 = '1, h2 = '1, h3 = '1, h4 = '1;

    always @(posedge clk) begin
        int c, l, ph, md;
        logic [3:1] pr;
        bit tk;
        c  = m_cnt;
        l  = m_lim;
        ph = m_ph;
        md = m_mode;
        if (rst) begin
            m_cnt  <= 0;
            m_lim  <= 0;
            m_ph   <= 0;
            m_mode <= M_IDLE;
            h1 <= '1; h2 <= '1; h3 <= '1; h4 <= '1;
        end else begin
            pr = h4 & ~h3;
            tk = (md == M_RUN) && (ph == P - 1);
            if (md == M_RUN) ph = (ph + 1) % P;
            else if (md != M_PAUSE) ph = 0;
            if (pr[2]) begin
                md = M_IDLE; c = 0; ph = 0;
            end else if (pr[1]) begin
                if (md == M_IDLE) md = M_RUN;
                else if (md == M_RUN) md = M_PAUSE;
                else if (md == M_PAUSE) md = M_RUN;
                else begin md = M_RUN; c = 0; ph = 0; end
            end else begin
                if (pr[3] && (md == M_IDLE || md == M_PAUSE)) l = sw;
                if (tk) begin
                    if (l != 0 && c + 1 == l) begin
                        c = l; md = M_DONE;
                    end else begin
                        c = (c + 1) % 1024;
                    end
                end
            end
            m_cnt  <= c;
            m_lim  <= l;
            m_ph   <= ph;
            m_mode <= md;
            h1 <= key; h2 <= h1; h3 <= h2; h4 <= h3;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; key = '1; sw = '0;
        cyc(); cyc();
        total++;
        if (ledr !== 10'd0) begin
            bad++; $display("FAIL reset_ledr got=%0d want=0", ledr);
        end
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%0b want=0", done);
        end
        total++;
        if (dut.state !== 2'd0) begin
            bad++; $display("FAIL reset_state got=%0d want=0", dut.state);
        end
        rst = 1'b0;
    endtask

    task automatic test_run();
        key = 3'b110;
        for (int i = 1; i <= 24; i++) begin
            cyc();
            if (i == 4) key = '1;
            total++;
            if (ledr !== m_cnt[9:0] || done !== (m_mode == M_DONE)) begin
                bad++;
                $display("FAIL run_model t=%0t ledr=%0d done=%0b want %0d/%0b",
                         $time, ledr, done, m_cnt, m_mode == M_DONE);
            end
            if (i == 23) begin
                total++;
                if (ledr !== 10'd4) begin
                    bad++; $display("FAIL run_19 got=%0d want=4", ledr);
                end
            end
            if (i == 24) begin
                total++;
                if (ledr !== 10'd5) begin
                    bad++; $display("FAIL run_20 got=%0d want=5", ledr);
                end
            end
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++;
        if (ledr !== 10'd0 || done !== 1'b0 || dut.state !== 2'd0) begin
            bad++;
            $display("FAIL run_reset ledr=%0d done=%0b state=%0d want 0/0/0",
                     ledr, done, dut.state);
        end
    endtask

    task automatic test_pause();
        logic [9:0] v;
        bit found;
        rst = 1'b1; cyc(); rst = 1'b0;
        key = 3'b110; cyc(); cyc(); key = '1;
        found = 0;
        v = ledr;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (ledr != v) found = 1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL pause_timeout got=0 want=1 increment");
        end
        v = ledr;
        cyc(); cyc();
        key = 3'b110;
        repeat (4) cyc();
        key = '1;
        total++;
        if (dut.state !== 2'd2 || ledr !== v + 10'd1) begin
            bad++;
            $display("FAIL pause_enter state=%0d ledr=%0d want 2/%0d",
                     dut.state, ledr, v + 10'd1);
        end
        for (int i = 0; i < 40; i++) begin
            cyc();
            total++;
            if (ledr !== v + 10'd1 || ledr !== m_cnt[9:0]) begin
                bad++;
                $display("FAIL pause_hold got=%0d want=%0d", ledr, v + 10'd1);
            end
        end
        key = 3'b110; cyc(); key = '1;
        cyc(); cyc();
        total++;
        if (dut.state !== 2'd2) begin
            bad++; $display("FAIL resume_early state=%0d want=2", dut.state);
        end
        cyc();
        total++;
        if (dut.state !== 2'd1 || ledr !== v + 10'd1) begin
            bad++;
            $display("FAIL resume state=%0d ledr=%0d want 1/%0d",
                     dut.state, ledr, v + 10'd1);
        end
        cyc();
        total++;
        if (ledr !== v + 10'd1) begin
            bad++; $display("FAIL resume_1 got=%0d want=%0d", ledr, v + 10'd1);
        end
        cyc();
        total++;
        if (ledr !== v + 10'd2 || ledr !== m_cnt[9:0]) begin
            bad++; $display("FAIL resume_2 got=%0d want=%0d", ledr, v + 10'd2);
        end
    endtask

    task automatic test_limit();
        int seq[$];
        int exp_seq[3] = '{1, 2, 3};
        int last;
        bit got_done;
        rst = 1'b1; cyc(); rst = 1'b0;
        sw = 10'd3;
        key = 3'b011; cyc(); cyc(); key = '1;
        repeat (4) cyc();
        total++;
        if (dut.limit !== 10'd3) begin
            bad++; $display("FAIL limit_load got=%0d want=3", dut.limit);
        end
        key = 3'b110; cyc(); key = '1;
        last = 0;
        got_done = 0;
        for (int i = 0; i < 60 && !got_done; i++) begin
            cyc();
            total++;
            if (ledr !== m_cnt[9:0] || done !== (m_mode == M_DONE)) begin
                bad++;
                $display("FAIL limit_model t=%0t ledr=%0d done=%0b want %0d/%0b",
                         $time, ledr, done, m_cnt, m_mode == M_DONE);
            end
            if (int'(ledr) != last) begin
                seq.push_back(int'(ledr));
                last = int'(ledr);
            end
            if (done) got_done = 1;
        end
        total++;
        if (!got_done || seq.size() != 3) begin
            bad++;
            $display("FAIL limit_seq done=%0b steps=%0d want 1/3", got_done, seq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (seq[i] != exp_seq[i]) begin
                    bad++; $display("FAIL limit_step%0d got=%0d want=%0d", i, seq[i], exp_seq[i]);
                end
            end
        end
        for (int i = 0; i < 25; i++) begin
            cyc();
            total++;
            if (done !== 1'b1 || ledr !== 10'd3) begin
                bad++; $display("FAIL done_hold done=%0b ledr=%0d want 1/3", done, ledr);
            end
        end
        key = 3'b110; cyc(); key = '1;
        cyc(); cyc(); cyc();
        total++;
        if (ledr !== 10'd0 || done !== 1'b0 || dut.state !== 2'd1) begin
            bad++;
            $display("FAIL done_restart ledr=%0d done=%0b state=%0d want 0/0/1",
                     ledr, done, dut.state);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] prev;
        bit wrapped, saw_done;
        rst = 1'b1; cyc(); rst = 1'b0;
        key = 3'b110; cyc(); key = '1;
        prev = ledr;
        wrapped = 0;
        saw_done = 0;
        for (int i = 0; i < 4300 && !wrapped; i++) begin
            cyc();
            if (done) saw_done = 1;
            if (prev == 10'd1023 && ledr == 10'd0) wrapped = 1;
            prev = ledr;
        end
        total++;
        if (!wrapped || ledr !== m_cnt[9:0]) begin
            bad++; $display("FAIL wrap seen=%0b ledr=%0d want 1/%0d", wrapped, ledr, m_cnt);
        end
        total++;
        if (saw_done) begin
            bad++; $display("FAIL wrap_done got=1 want=0");
        end
    endtask

    task automatic test_simultaneous();
        logic [9:0] prev;
        bit wrapped, saw_done;
        rst = 1'b1; cyc(); rst = 1'b0;
        key = 3'b110; cyc(); key = '1;
        repeat (10) cyc();
        key = 3'b100;
        repeat (4) cyc();
        key = '1;
        total++;
        if (dut.state !== 2'd0 || ledr !== 10'd0) begin
            bad++;
            $display("FAIL both_keys state=%0d ledr=%0d want 0/0", dut.state, ledr);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++;
            if (ledr !== 10'd0 || ledr !== m_cnt[9:0]) begin
                bad++; $display("FAIL both_idle got=%0d want=0", ledr);
            end
        end
        key = 3'b110; cyc(); key = '1;
        repeat (8) cyc();
        sw = 10'd7;
        key = 3'b011; cyc(); cyc(); key = '1;
        repeat (6) cyc();
        total++;
        if (dut.limit !== 10'd0 || dut.state !== 2'd1) begin
            bad++;
            $display("FAIL load_in_run limit=%0d state=%0d want 0/1", dut.limit, dut.state);
        end
        prev = ledr;
        wrapped = 0;
        saw_done = 0;
        for (int i = 0; i < 4300 && !wrapped; i++) begin
            cyc();
            if (done) saw_done = 1;
            if (prev == 10'd1023 && ledr == 10'd0) wrapped = 1;
            prev = ledr;
        end
        total++;
        if (!wrapped || saw_done) begin
            bad++;
            $display("FAIL ignored_load wrap=%0b done_seen=%0b want 1/0", wrapped, saw_done);
        end
    endtask

    task automatic test_random();
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int b = 1; b <= 3; b++) key[b] = ($urandom_range(0, 2) != 0);
            end
            if ($urandom_range(0, 15) == 0) sw = 10'($urandom_range(0, 12));
            rst = ($urandom_range(0, 599) == 0);
            cyc();
            total++;
            if (ledr !== m_cnt[9:0] || done !== (m_mode == M_DONE)) begin
                bad++;
                $display("FAIL random_model t=%0t ledr=%0d done=%0b want %0d/%0b",
                         $time, ledr, done, m_cnt, m_mode == M_DONE);
            end
        end
        rst = 1'b0;
        key = '1;
    endtask

    task automatic test_debounce();
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        key = 3'b110;
        repeat (8) cyc();
        key = '1;
        repeat (40) cyc();
        total++;
        if (dut.state !== 2'd0 || ledr !== 10'd0) begin
            bad++;
            $display("FAIL deb_short state=%0d ledr=%0d want 0/0", dut.state, ledr);
        end
        key = 3'b110;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (i == 19) begin
                total++;
                if (dut.state !== 2'd0) begin
                    bad++; $display("FAIL deb_early state=%0d want=0", dut.state);
                end
            end
            if (i == 20) begin
                total++;
                if (dut.state !== 2'd1) begin
                    bad++; $display("FAIL deb_start state=%0d want=1", dut.state);
                end
            end
        end
        key = '1;
        repeat (40) cyc();
        total++;
        if (dut.state !== 2'd1) begin
            bad++; $display("FAIL deb_single state=%0d want=1", dut.state);
        end
    endtask

    initial begin
        test_reset();
`ifdef COUNTER_CTRL_DEBOUNCE_EN
        test_debounce();
`else
        test_run();
        test_pause();
        test_limit();
        test_wrap();
        test_simultaneous();
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Pushbutton-driven sequencer for a 10-bit event counter on the DE1-SoC board. It converts active-low KEY presses into single-cycle commands: start/pause, clear and load-limit. It runs a prescaler that gates the counter increment, and stops the counter at a programmable terminal value. It sits between the board pins (KEY, SW) and the LEDR display, and replaces the free-running counter in demos that need controlled counting.

## Interface
- PRESCALE, 5_000_000, CLOCK_50 cycles per count increment. Must be ≥ 2.
- DEBOUNCE_CYCLES, 16, number of consecutive low samples needed to accept a press. Used only when COUNTER_CTRL_DEBOUNCE_EN is defined.
- CLOCK_50  input  1  system clock; the only clock.
- Reset  input  1  synchronous, active-high reset. The top level drives it as ~KEY[0].
- KEY  input  [3:1]  active-low pushbuttons, asynchronous to CLOCK_50: KEY[1] start/pause, KEY[2] clear, KEY[3] load limit.
- SW  input  [9:0]  limit value, sampled on a load command.
- LEDR  output  [9:0]  current count value.
- done  output  1  high while the counter sits at its limit.

## Operation
- Each KEY bit passes through a 2-flop synchronizer. A press is a 1→0 transition of the synchronized value and produces a one-cycle pulse: start_p, clear_p or load_p.
- Registers:
  - Count, 10 bits.
  - Limit, 10 bits.
  - Presc, $clog2(PRESCALE) bits.
  - State, one of IDLE, RUN, PAUSE, DONE.
- Command priority within a cycle: clear_p > start_p > load_p.
- clear_p in any state: Count=0, Presc=0, State→IDLE. Limit is kept.
- start_p transitions:
  - IDLE→RUN.
  - RUN→PAUSE.
  - PAUSE→RUN.
  - DONE→RUN, with Count=0 and Presc=0.
- load_p:
  - In IDLE or PAUSE: Limit=SW.
  - In RUN or DONE: ignored.
- Prescaler behaviour:
  - In RUN, Presc increments every cycle. When Presc==PRESCALE-1, Presc→0 and a tick fires.
  - In PAUSE, Presc holds, so a resumed count keeps its partial period.
  - In IDLE and DONE, Presc=0.
- On a tick in RUN:
  - If Limit≠0 and Count+1==Limit: Count=Limit, State→DONE.
  - Otherwise Count=Count+1, with modulo-2^10 wrap.
  - Limit=0 means free-running: 1023 wraps to 0 and the block never enters DONE.
  - When Limit≠0, the ≥ comparison is not used. A Limit loaded below the current Count (from PAUSE) is reached only after Count wraps.
- Outputs: LEDR=Count. done=(State==DONE).
- Reset sets Count=0, Limit=0, Presc=0, State=IDLE, LEDR=0, done=0, and clears the synchronizer and edge flops to 1 (released). Reset takes priority over every command and tick, including mid-RUN.

## Timing
- Key-to-state latency without debounce:
  - KEY first sampled low at edge k.
  - The command pulse is high during the cycle after edge k+2.
  - State and registers update at edge k+3.
- With debounce, the pulse comes DEBOUNCE_CYCLES cycles later than without debounce.
- Holding a key produces exactly one pulse. A new press needs a release (synchronized 1) first.
- Tick timing:
  - First increment after IDLE→RUN occurs at the PRESCALE-th edge after the transition edge.
  - Later increments come every PRESCALE cycles.
  - A tick and a command in the same cycle: the command wins. With clear_p or start_p present, the tick's increment is discarded.
- LEDR and done are registered outputs and reflect the state after each edge. There is no combinational path from KEY or SW to any output.

## Configuration
- COUNTER_CTRL_DEBOUNCE_EN defined:
  - Each synchronized key feeds a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The debounced level goes low only after DEBOUNCE_CYCLES consecutive low samples and goes high after the same count of high samples.
  - The press pulse is taken from the debounced level.
- COUNTER_CTRL_DEBOUNCE_EN undefined: the pulse is taken directly from the synchronized level, and DEBOUNCE_CYCLES is ignored.

## Structure
- Shared package holds:
  - The state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - COUNT_W=10.
  - The KEY index constants: KEY_START=1, KEY_CLEAR=2, KEY_LOAD=3.
- Sub-module key_press:
  - One instance per KEY bit.
  - Contains the synchronizer, the optional debounce under the macro, and the falling-edge detector.
  - Ports: CLOCK_50, Reset, key_n, press.
- counter_ctrl contains the FSM, prescaler, Count and Limit.

## Test plan
All scenarios use PRESCALE=4 with no debounce unless stated.
- Reset and run:
  - Stimulus: assert Reset for 2 cycles.
  - Response: LEDR=0, done=0.
  - Stimulus: press KEY[1], then wait 20 cycles after the transition.
  - Response: LEDR=5.
  - Stimulus: assert Reset for 1 cycle.
  - Response: LEDR=0 and State=IDLE on the next edge.
- Pause and resume:
  - Stimulus: in RUN, press KEY[1] 2 cycles after an increment, hold PAUSE for 40 cycles, then press KEY[1] again.
  - Response: LEDR is unchanged during PAUSE. The next increment comes 2 cycles after resume.
- Limit and DONE:
  - Stimulus: SW=3, press KEY[3] in IDLE, then press KEY[1].
  - Response: LEDR counts 1, 2, 3. done=1 with LEDR=3, held for more than 20 cycles.
  - Stimulus: press KEY[1] again.
  - Response: LEDR=0 and RUN.
- Wrap with Limit=0:
  - Stimulus: let the counter run past 1023.
  - Response: LEDR goes 1023→0 on the tick, and done stays 0.
- Simultaneous commands and ignored load:
  - Stimulus: press KEY[1] and KEY[2] in the same cycle while in RUN.
  - Response: IDLE, LEDR=0.
  - Stimulus: press KEY[3] during RUN with SW=7, then continue to 1023.
  - Response: Limit stays unchanged; the counter wraps and never enters DONE.
- Debounce (COUNTER_CTRL_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=16):
  - Stimulus: hold KEY[1] low for 8 cycles.
  - Response: no state change.
  - Stimulus: hold KEY[1] low for 30 cycles.
  - Response: exactly one IDLE→RUN transition, 19 cycles after KEY goes low.
